// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared opcodes, FSM state encodings and default SRAM geometry
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 7;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_RD_LAT = 2;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_COPY  = 2'b11
    } op_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_ISSUE = 3'd1;
    localparam state_t ST_RD_WAIT  = 3'd2;
    localparam state_t ST_RD_CAPT  = 3'd3;
    localparam state_t ST_WR_ISSUE = 3'd4;
    localparam state_t ST_CP_WR    = 3'd5;
    localparam state_t ST_RESP     = 3'd6;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - saturating wait counter with programmable rollover and done flag
module sram_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] rollover,
    output logic         done
);

    logic [W-1:0] count;

    // Saturates at rollover so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != rollover)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == rollover);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-command SRAM responder for READ, WRITE and COPY with fixed read latency
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int RD_LAT = SRAM_RD_LAT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] address_one,
    input  logic [ADDR_W-1:0] address_two,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int                CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] ROLLOVER = CNT_W'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    op_t               cap_op;
    logic [ADDR_W-1:0] cap_a1;
    logic [ADDR_W-1:0] cap_a2;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] rd_word;
    logic              accept;
    logic              start_rd;
    logic              wait_done;

    assign accept   = req_valid && (state == ST_IDLE);
    assign start_rd = accept && ((op_code == OP_READ) || (op_code == OP_COPY));

    // The issue cycle counts toward the latency, so RD_WAIT lasts RD_LAT-1 cycles.
    sram_wait_counter #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (start_rd),
        .enable   ((state == ST_RD_ISSUE) || (state == ST_RD_WAIT)),
        .rollover (ROLLOVER),
        .done     (wait_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    case (op_code)
                        OP_READ, OP_COPY: state_nxt = ST_RD_ISSUE;
                        OP_WRITE:         state_nxt = ST_WR_ISSUE;
                        default:          state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_RD_ISSUE: state_nxt = (RD_LAT == 1) ? ST_RD_CAPT : ST_RD_WAIT;
            ST_RD_WAIT:  if (wait_done) state_nxt = ST_RD_CAPT;
            ST_RD_CAPT:  state_nxt = (cap_op == OP_COPY) ? ST_CP_WR : ST_RESP;
            ST_WR_ISSUE: state_nxt = ST_RESP;
            ST_CP_WR:    state_nxt = ST_RESP;
            ST_RESP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            cap_op   <= OP_NOP;
            cap_a1   <= '0;
            cap_a2   <= '0;
            cap_data <= '0;
            rd_word  <= '0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_op   <= op_t'(op_code);
                cap_a1   <= address_one;
                cap_a2   <= address_two;
                cap_data <= data_in;
            end
            if (state == ST_RD_CAPT) begin
                rd_word <= sram_rdata;
                if (cap_op == OP_READ) begin
                    data_out <= sram_rdata;
                end
            end
            // A COPY only publishes its word once the write-back has been issued.
            if (state == ST_CP_WR) begin
                data_out <= rd_word;
            end
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign sram_ren   = (state == ST_RD_ISSUE);
    assign sram_wen   = (state == ST_WR_ISSUE) || (state == ST_CP_WR);

    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            ST_RD_ISSUE: sram_addr = cap_a1;
            ST_WR_ISSUE: begin
                sram_addr  = cap_a1;
                sram_wdata = cap_data;
            end
            ST_CP_WR: begin
                sram_addr  = cap_a2;
                sram_wdata = rd_word;
            end
            default: begin
                sram_addr  = '0;
                sram_wdata = '0;
            end
        endcase
    end

endmodule
